// File: rtl/router_pkt_sink.sv
// ---------------------------------------------------------------------------
// router_pkt_sink
//
// Receive-side endpoint for one router output port. It drains the port FIFO
// and rebuilds each packet:
//   header {len[5:0], addr[1:0]}, len payload bytes, then one parity byte.
// Every byte is streamed downstream with start/end marks. The parity byte is
// checked against the XOR of the header and the payload. A packet whose FIFO
// stays empty for TIMEOUT cycles mid-packet is dropped with trunc_err.
//
// Handshake (FIFO side): the FIFO is read with read_enb. A read seen at
// rising edge k presents its byte on data_out during the following cycle,
// and that byte is captured at edge k+1. read_enb is only raised while
// vld_out=1, sink_ready=1 and the current packet still has unread bytes.
// As a result the sink never reads into the next packet. Downstream has no
// back-pressure on a captured byte: sink_ready only stops new reads, so at
// most one byte is still in flight after sink_ready falls.
//
// Ports
//   clock       in   rising-edge clock
//   resetn      in   asynchronous active-low reset
//   vld_out     in   router FIFO non-empty
//   data_out    in   router FIFO read data (1-cycle read latency)
//   read_enb    out  FIFO read strobe (combinational)
//   sink_ready  in   downstream can take bytes; low stalls new reads
//   byte_data   out  captured byte
//   byte_valid  out  byte_data valid this cycle (pulse)
//   byte_sop    out  byte is a header (pulse)
//   byte_eop    out  byte is parity (pulse)
//   pkt_done    out  packet complete (pulse)
//   pkt_addr    out  header addr of the last/current packet
//   pkt_len     out  header length of the last/current packet
//   parity_err  out  parity mismatch, updated with pkt_done
//   trunc_err   out  packet aborted by timeout (pulse)
//   state_dbg   out  current FSM state (IDLE=0, HDR=1, BODY=2)
// ---------------------------------------------------------------------------
module router_pkt_sink #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       vld_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    input  logic       sink_ready,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       byte_sop,
    output logic       byte_eop,
    output logic       pkt_done,
    output logic [1:0] pkt_addr,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       trunc_err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;

    // Byte counters after the header. remain is len+1 (payload plus parity).
    // It is 7 bits wide because len=63 gives 64.
    logic [6:0]         issued;
    logic [6:0]         captured;
    logic [6:0]         remain;
    logic [7:0]         acc;
    logic [CNT_W-1:0]   tmo_cnt;

    // A read was issued at the previous edge, so data_out holds a byte now.
    logic               rd_pend;

    logic               rd_issue;
    logic               reads_left;
    logic               last_cap;
    logic               tmo_hit;
    logic [6:0]         captured_nx;

    // ------------------------------------------------------------------
    // Next state and read strobe
    // ------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        rd_issue    = 1'b0;
        last_cap    = 1'b0;
        tmo_hit     = 1'b0;
        reads_left  = (issued < remain);
        captured_nx = captured + 7'd1;

        case (state)
            IDLE: begin
                rd_issue = vld_out & sink_ready;
                if (rd_issue) begin
                    state_nx = HDR;
                end
            end

            HDR: begin
                // The header byte is on data_out. The length is not known
                // until this byte is captured, so no read is issued here.
                state_nx = BODY;
            end

            BODY: begin
                rd_issue = vld_out & sink_ready & reads_left;
                last_cap = rd_pend & (captured_nx == remain);
                // The count only runs while bytes are still owed. The last
                // capture always comes with reads_left=0, so last_cap and
                // tmo_hit are never both true.
                tmo_hit  = ~vld_out & reads_left &
                           (tmo_cnt == CNT_W'(TIMEOUT - 1));
                if (last_cap || tmo_hit) begin
                    state_nx = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // Reset is folded in so the strobe is also low while reset is held.
    assign read_enb  = rd_issue & resetn;
    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            issued     <= '0;
            captured   <= '0;
            remain     <= '0;
            acc        <= '0;
            tmo_cnt    <= '0;
            rd_pend    <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_sop   <= 1'b0;
            byte_eop   <= 1'b0;
            pkt_done   <= 1'b0;
            pkt_addr   <= '0;
            pkt_len    <= '0;
            parity_err <= 1'b0;
            trunc_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_pend    <= rd_issue;

            // Single-cycle strobes by default.
            byte_valid <= 1'b0;
            byte_sop   <= 1'b0;
            byte_eop   <= 1'b0;
            pkt_done   <= 1'b0;
            trunc_err  <= 1'b0;

            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (rd_issue) begin
                        acc <= '0;
                    end
                end

                HDR: begin
                    byte_data  <= data_out;
                    byte_valid <= 1'b1;
                    byte_sop   <= 1'b1;
                    pkt_len    <= data_out[7:2];
                    pkt_addr   <= data_out[1:0];
                    acc        <= data_out;
                    issued     <= '0;
                    captured   <= '0;
                    remain     <= {1'b0, data_out[7:2]} + 7'd1;
                    tmo_cnt    <= '0;
                end

                BODY: begin
                    if (rd_issue) begin
                        issued <= issued + 7'd1;
                    end

                    if (rd_pend) begin
                        byte_data  <= data_out;
                        byte_valid <= 1'b1;
                        captured   <= captured_nx;
                        if (last_cap) begin
                            byte_eop   <= 1'b1;
                            pkt_done   <= 1'b1;
                            parity_err <= (acc != data_out);
                        end else begin
                            acc <= acc ^ data_out;
                        end
                    end

                    // Any cycle with data in the FIFO restarts the window.
                    // A sink_ready stall with vld_out=1 does not count.
                    if (vld_out) begin
                        tmo_cnt <= '0;
                    end else if (reads_left) begin
                        if (tmo_hit) begin
                            tmo_cnt   <= '0;
                            trunc_err <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + CNT_W'(1);
                        end
                    end
                end

                default: begin
                    tmo_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_sink.sv
module tb_router_pkt_sink;

  logic       clock = 1'b0;
  logic       resetn;
  logic       vld_out;
  logic [7:0] data_out = 8'h00;
  logic       read_enb;
  logic       sink_ready;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_sop;
  logic       byte_eop;
  logic       pkt_done;
  logic [1:0] pkt_addr;
  logic [5:0] pkt_len;
  logic       parity_err;
  logic       trunc_err;
  logic [1:0] state_dbg;

  router_pkt_sink #(.TIMEOUT(30), .CNT_W(5)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .read_enb   (read_enb),
    .sink_ready (sink_ready),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_sop   (byte_sop),
    .byte_eop   (byte_eop),
    .pkt_done   (pkt_done),
    .pkt_addr   (pkt_addr),
    .pkt_len    (pkt_len),
    .parity_err (parity_err),
    .trunc_err  (trunc_err),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- router FIFO model ----------------
  logic [7:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int viol_cnt = 0;
  int watch_idx = -1;
  int hdr2_cyc = 0;
  int empty_cyc = 0;

  assign vld_out = (wr_ptr != rd_ptr);

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (read_enb) begin
      if (!vld_out || !sink_ready) viol_cnt <= viol_cnt + 1;
      data_out <= fifo_mem[rd_ptr[9:0]];
      rd_ptr <= rd_ptr + 1;
      if (rd_ptr == watch_idx) hdr2_cyc <= cyc + 1;
      if (rd_ptr + 1 == wr_ptr) empty_cyc <= cyc + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];      // {sop, eop, data}
  logic [8:0] exp_pkt_q[$];  // {parity_err, len, addr}
  int n_chk = 0;
  int n_bad = 0;
  int done_seen = 0;
  int trunc_seen = 0;
  int trunc_cyc = 0;
  int eop_first = 0;

  typedef struct {
    logic [5:0] len;
    logic [1:0] addr;
    logic       bad;
    logic       exp_perr;
  } vec_t;
  vec_t tab [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    logic [9:0] e;
    logic [8:0] p;
    if (byte_valid) begin
      chk("byte_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte", {byte_sop, byte_eop, byte_data}, e);
      end
      if (byte_eop && eop_first == 0) eop_first = cyc;
    end
    if (pkt_done) begin
      done_seen++;
      chk("pkt_expected", exp_pkt_q.size() != 0, 1);
      if (exp_pkt_q.size() != 0) begin
        p = exp_pkt_q.pop_front();
        chk("pkt_status", {parity_err, pkt_len, pkt_addr}, p);
      end
    end
    if (trunc_err) begin
      trunc_seen++;
      trunc_cyc = cyc;
      chk("trunc_no_done", pkt_done, 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic fifo_put(input logic [7:0] b);
    fifo_mem[wr_ptr[9:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  // ncut < 0: full packet; otherwise only header + ncut payload bytes.
  task automatic push_pkt(input logic [5:0] len, input logic [1:0] addr,
                          input logic bad, input int ncut);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] b;
    int n;
    hdr = {len, addr};
    par = hdr;
    fifo_put(hdr);
    exp_q.push_back({2'b10, hdr});
    n = (ncut < 0) ? int'(len) : ncut;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      par = par ^ b;
      fifo_put(b);
      exp_q.push_back({2'b00, b});
    end
    if (ncut < 0) begin
      par = par ^ {7'd0, bad};
      fifo_put(par);
      exp_q.push_back({2'b01, par});
      exp_pkt_q.push_back({bad, len, addr});
    end
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (done_seen < target && k < 2000) begin
      @(posedge clock);
      k++;
    end
    @(negedge clock);
    chk(name, done_seen >= target, 1);
  endtask

  task automatic wait_reads(input int base, input int n, input string name);
    int k = 0;
    while ((rd_ptr - base) < n && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk(name, (rd_ptr - base) >= n, 1);
  endtask

  function automatic logic [24:0] all_outs();
    return {read_enb, byte_data, byte_valid, byte_sop, byte_eop, pkt_done,
            pkt_addr, pkt_len, parity_err, trunc_err, state_dbg};
  endfunction

  // ---------------- test ----------------
  initial begin
    int base;
    int d0;
    int t0;

    tab[0] = '{len: 6'd5,  addr: 2'd2, bad: 1'b0, exp_perr: 1'b0};
    tab[1] = '{len: 6'd5,  addr: 2'd2, bad: 1'b1, exp_perr: 1'b1};
    tab[2] = '{len: 6'd0,  addr: 2'd1, bad: 1'b0, exp_perr: 1'b0};
    tab[3] = '{len: 6'd0,  addr: 2'd3, bad: 1'b1, exp_perr: 1'b1};
    tab[4] = '{len: 6'd63, addr: 2'd0, bad: 1'b0, exp_perr: 1'b0};
    tab[5] = '{len: 6'd1,  addr: 2'd1, bad: 1'b0, exp_perr: 1'b0};

    resetn = 1'b0;
    sink_ready = 1'b1;
    fork
      forever begin
        @(posedge clock);
        #1;
        mon_step();
      end
    join_none

    #1;
    chk("reset_outputs", all_outs(), 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_after_reset", all_outs(), 0);

    // Table-driven single packets.
    for (int i = 0; i < 6; i++) begin
      base = rd_ptr;
      d0 = done_seen;
      push_pkt(tab[i].len, tab[i].addr, tab[i].bad, -1);
      wait_done(d0 + 1, "tab_done");
      repeat (2) @(negedge clock);
      chk("tab_reads", rd_ptr - base, int'(tab[i].len) + 2);
      chk("tab_perr", parity_err, tab[i].exp_perr);
      chk("tab_len", pkt_len, tab[i].len);
      chk("tab_addr", pkt_addr, tab[i].addr);
      chk("tab_idle", state_dbg, 0);
    end

    // Back-to-back: len 14 then len 16 queued together.
    base = rd_ptr;
    d0 = done_seen;
    eop_first = 0;
    watch_idx = wr_ptr + 16;
    push_pkt(6'd14, 2'd1, 1'b0, -1);
    push_pkt(6'd16, 2'd3, 1'b0, -1);
    wait_done(d0 + 2, "b2b_done");
    repeat (2) @(negedge clock);
    chk("b2b_reads", rd_ptr - base, 34);
    chk("b2b_hdr2_after_eop", hdr2_cyc > eop_first, 1);
    chk("b2b_len2", pkt_len, 16);
    watch_idx = -1;

    // sink_ready stall mid-payload of a len 16 packet.
    base = rd_ptr;
    d0 = done_seen;
    t0 = trunc_seen;
    push_pkt(6'd16, 2'd0, 1'b0, -1);
    wait_reads(base, 6, "stall_mid");
    sink_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("stall_read_enb", read_enb, 0);
      @(negedge clock);
    end
    sink_ready = 1'b1;
    wait_done(d0 + 1, "stall_done");
    chk("stall_no_trunc", trunc_seen, t0);
    chk("stall_perr", parity_err, 0);

    // Truncation: len 10 header with only 3 payload bytes.
    d0 = done_seen;
    t0 = trunc_seen;
    push_pkt(6'd10, 2'd2, 1'b0, 3);
    begin
      int k = 0;
      while (trunc_seen == t0 && k < 200) begin
        @(negedge clock);
        k++;
      end
    end
    repeat (3) @(negedge clock);
    chk("trunc_pulse_once", trunc_seen, t0 + 1);
    chk("trunc_delay", trunc_cyc - empty_cyc, 30);
    chk("trunc_no_pkt_done", done_seen, d0);
    chk("trunc_idle", state_dbg, 0);
    push_pkt(6'd3, 2'd1, 1'b0, -1);
    wait_done(d0 + 1, "after_trunc_done");
    chk("after_trunc_len", pkt_len, 3);

    // Reset mid-payload.
    base = rd_ptr;
    d0 = done_seen;
    push_pkt(6'd16, 2'd2, 1'b0, -1);
    wait_reads(base, 6, "rst_mid");
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_mid_outputs", all_outs(), 0);
    exp_q.delete();
    exp_pkt_q.delete();
    wr_ptr = rd_ptr;
    repeat (2) @(negedge clock);
    chk("rst_hold_outputs", all_outs(), 0);
    resetn = 1'b1;
    @(negedge clock);
    push_pkt(6'd1, 2'd0, 1'b0, -1);
    wait_done(d0 + 1, "post_rst_done");
    chk("post_rst_len", pkt_len, 1);
    chk("post_rst_addr", pkt_addr, 0);

    repeat (3) @(negedge clock);
    chk("sb_empty", exp_q.size() + exp_pkt_q.size(), 0);
    chk("read_rules", viol_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_sink.md
Name: router_pkt_sink

Overview:
- Receive-side endpoint for one router output port (data_out_N / vld_out_N / read_enb_N).
- Drains the port's FIFO and reassembles each packet: header {len[5:0], addr[1:0]}, len payload bytes, then parity.
- Checks XOR parity, streams bytes downstream with start/end marks and reports per-packet status.
- Instantiated once per router output channel, in the verification harness or in downstream logic.

Parameters:
- TIMEOUT, 30: cycles of vld_out low mid-packet before the packet is declared truncated. Matches the router soft-reset window.
- CNT_W, 5: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- vld_out  in  1  router FIFO non-empty.
- data_out  in  8  router FIFO read data; valid the cycle after a sampled read_enb.
- read_enb  out  1  FIFO read strobe (combinational from state, counters, vld_out and sink_ready).
- sink_ready  in  1  downstream may accept bytes; low stalls new reads.
- byte_data  out  8  captured byte.
- byte_valid  out  1  byte_data valid this cycle.
- byte_sop  out  1  byte is a header.
- byte_eop  out  1  byte is parity.
- pkt_done  out  1  one-cycle pulse: packet complete.
- pkt_addr  out  2  header addr of the last/current packet.
- pkt_len  out  6  header length of the last/current packet.
- parity_err  out  1  valid with pkt_done; 1 = parity mismatch.
- trunc_err  out  1  one-cycle pulse: packet aborted by timeout.

Behaviour:
- Reset (async, any time, including mid-packet): state=IDLE; all counters 0; every output 0; in-flight packet discarded.
- Read latency is 1 cycle: a byte issued by read_enb=1 at edge k is captured from data_out at edge k+1.
- read_enb is never asserted while vld_out=0, while sink_ready=0, or beyond the current packet's last byte.
- The block therefore never over-reads into the next packet.
- IDLE:
  - read_enb = vld_out & sink_ready.
  - On a read, go to HDR and clear the parity accumulator.
- HDR:
  - read_enb = 0.
  - Capture data_out as header: byte_valid=1, byte_sop=1.
  - Load pkt_len=data_out[7:2] and pkt_addr=data_out[1:0].
  - Set acc=data_out, issued=0, remain=pkt_len+1 (7-bit). Go to BODY.
- BODY:
  - read_enb = vld_out & sink_ready & (issued < remain).
  - Each cycle following a read, capture data_out with byte_valid=1.
  - While captured count < remain: that byte is payload; acc ^= byte.
  - When captured count == remain: that byte is parity; set byte_eop=1, pulse pkt_done, set parity_err = (acc != byte). Go to IDLE.
  - Back-to-back packets: IDLE may issue the next header read in the cycle after parity is captured. No dead cycle is required beyond that.
  - pkt_len=0: only the parity byte follows the header.
- Timeout:
  - In BODY, a counter increments each cycle with reads outstanding and vld_out=0.
  - The counter clears on any cycle with vld_out=1.
  - When the counter reaches TIMEOUT: pulse trunc_err, no pkt_done, go to IDLE.
  - sink_ready=0 with vld_out=1 does not count toward timeout.
- Outputs:
  - byte_valid, byte_sop, byte_eop, pkt_done and trunc_err are registered pulses, low otherwise.
  - parity_err holds until the next pkt_done or a reset.
  - pkt_addr and pkt_len hold until the next header.
- A simultaneous vld_out drop and last read issue is legal; the final byte is still captured the next cycle.

Test Plan:
- Header 0x16 (len 5, addr 2), payload 5 random bytes, correct parity -> read_enb high for exactly 7 issue cycles, 7 byte_valid, pkt_len=5, pkt_addr=2, pkt_done with parity_err=0.
- Same packet with the parity byte XOR 0x01 -> pkt_done=1, parity_err=1, byte_eop on the 7th byte.
- Len 14 then len 16 queued back-to-back in the FIFO -> two pkt_done pulses; the second header is not read before the first parity is captured; pkt_len=14 then 16.
- Hold sink_ready=0 for 10 cycles mid-payload of a len 16 packet -> read_enb=0 throughout, no trunc_err, packet completes with correct parity.
- vld_out drops after 3 payload bytes of a len 10 packet -> trunc_err pulse exactly 30 cycles later, no pkt_done, state IDLE; a following valid packet is received correctly.
- resetn pulsed low mid-payload -> all outputs 0 immediately; after release, a new 0x04 header (len 1) is received with pkt_done.
